mdio_slave: RTL and testbench

MDIO_SLAVE -- requirements
Module: mdio_slave

---
 rtl/mdio_slave.sv | 224 ++++++++++++++++++++++
 tb/tb_mdio_slave.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_slave.sv
// Clause 22 MDIO responder: preamble/frame decode, register strobes, read drive.
// Define MDIO_SLAVE_PREAMBLE_SUPPRESS_EN to accept a 1-bit preamble after a completed frame.
module mdio_slave #(
  parameter logic [4:0] PHY_ADDR      = 5'd1,
  parameter int         PREAMBLE_BITS = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe_o,
  output logic [4:0]  reg_addr_o,
  output logic        reg_rd_o,
  input  logic [15:0] reg_rdata_i,
  output logic        reg_wr_o,
  output logic [15:0] reg_wdata_o
);
  localparam int CW = $clog2(PREAMBLE_BITS + 1);
  localparam logic [CW-1:0] PRE = CW'(PREAMBLE_BITS);
`ifdef MDIO_SLAVE_PREAMBLE_SUPPRESS_EN
  localparam logic SUP_EN = 1'b1;
`else
  localparam logic SUP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, START, OP, PHYAD, REGAD, TA, RDATA, WDATA
  } state_t;

  state_t state_q, state_d;
  logic mdc_s1, mdc_s2, mdc_q, mdio_s1, mdio_s2;
  logic [CW-1:0] pre_q, pre_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] sh_q, sh_d, sh_in;
  logic [15:0] rsh_q, rsh_d;
  logic rd_q, rd_d, cap_q, sup_q, sup_d;
  logic o_d, oe_d, rdstb_d, wrstb_d;
  logic [4:0]  addr_d;
  logic [15:0] wdata_d;
  logic edge_w, bit_w, pre_ok, abort, done;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mdc_s1  <= 1'b1;
      mdc_s2  <= 1'b1;
      mdc_q   <= 1'b1;
      mdio_s1 <= 1'b1;
      mdio_s2 <= 1'b1;
    end else begin
      mdc_s1  <= mdc_i;
      mdc_s2  <= mdc_s1;
      mdc_q   <= mdc_s2;
      mdio_s1 <= mdio_i;
      mdio_s2 <= mdio_s1;
    end
  end

  assign edge_w = mdc_s2 & ~mdc_q;
  assign bit_w  = mdio_s2;
  assign sh_in  = {sh_q[14:0], bit_w};
  assign pre_ok = (pre_q == PRE) || (SUP_EN && sup_q && pre_q != '0);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    rd_d    = rd_q;
    rsh_d   = cap_q ? reg_rdata_i : rsh_q;
    sup_d   = sup_q;
    o_d     = mdio_o;
    oe_d    = mdio_oe_o;
    addr_d  = reg_addr_o;
    wdata_d = reg_wdata_o;
    rdstb_d = 1'b0;
    wrstb_d = 1'b0;
    abort   = 1'b0;
    done    = 1'b0;
    if (edge_w) begin
      unique case (state_q)
        IDLE: begin
          if (bit_w) begin
            if (pre_q != PRE) pre_d = pre_q + 1'b1;
          end else begin
            if (pre_ok) state_d = START;
            pre_d = '0;
          end
        end
        START: begin
          if (bit_w) begin
            state_d = OP;
            cnt_d   = '0;
          end else begin
            abort = 1'b1;
          end
        end
        OP: begin
          sh_d = sh_in;
          if (cnt_q == 5'd1) begin
            cnt_d   = '0;
            state_d = PHYAD;
            rd_d    = sh_in[1];
            if (sh_in[1] == sh_in[0]) abort = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PHYAD: begin
          sh_d = sh_in;
          if (cnt_q == 5'd4) begin
            cnt_d   = '0;
            state_d = REGAD;
            if (sh_in[4:0] != PHY_ADDR) abort = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        REGAD: begin
          sh_d = sh_in;
          if (cnt_q == 5'd4) begin
            cnt_d   = '0;
            state_d = TA;
            addr_d  = sh_in[4:0];
            rdstb_d = rd_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        TA: begin
          if (rd_q) begin
            if (cnt_q == 5'd0) begin
              oe_d  = 1'b1;
              o_d   = 1'b0;
              cnt_d = 5'd1;
            end else begin
              o_d     = rsh_q[15];
              rsh_d   = {rsh_q[14:0], 1'b0};
              cnt_d   = '0;
              state_d = RDATA;
            end
          end else if (cnt_q == 5'd0) begin
            if (bit_w) cnt_d = 5'd1;
            else abort = 1'b1;
          end else if (!bit_w) begin
            cnt_d   = '0;
            state_d = WDATA;
          end else begin
            abort = 1'b1;
          end
        end
        RDATA: begin
          if (cnt_q == 5'd15) begin
            oe_d = 1'b0;
            o_d  = 1'b1;
            done = 1'b1;
          end else begin
            o_d   = rsh_q[15];
            rsh_d = {rsh_q[14:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
          end
        end
        WDATA: begin
          sh_d = sh_in;
          if (cnt_q == 5'd15) begin
            wdata_d = sh_in;
            wrstb_d = 1'b1;
            done    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: abort = 1'b1;
      endcase
    end
    // Aborted frames also forfeit the short-preamble allowance.
    if (abort) begin
      state_d = IDLE;
      pre_d   = '0;
      sup_d   = 1'b0;
      oe_d    = 1'b0;
      o_d     = 1'b1;
    end
    if (done) begin
      state_d = IDLE;
      pre_d   = '0;
      sup_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      pre_q       <= '0;
      cnt_q       <= '0;
      sh_q        <= '0;
      rsh_q       <= '0;
      rd_q        <= 1'b0;
      cap_q       <= 1'b0;
      sup_q       <= 1'b0;
      mdio_o      <= 1'b1;
      mdio_oe_o   <= 1'b0;
      reg_addr_o  <= '0;
      reg_rd_o    <= 1'b0;
      reg_wr_o    <= 1'b0;
      reg_wdata_o <= '0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      rsh_q       <= rsh_d;
      rd_q        <= rd_d;
      cap_q       <= reg_rd_o;
      sup_q       <= sup_d;
      mdio_o      <= o_d;
      mdio_oe_o   <= oe_d;
      reg_addr_o  <= addr_d;
      reg_rd_o    <= rdstb_d;
      reg_wr_o    <= wrstb_d;
      reg_wdata_o <= wdata_d;
    end
  end
endmodule

// File: tb/tb_mdio_slave.sv
// Directed MDIO frames against mdio_slave; strobes checked by a queued scoreboard.
module tb_mdio_slave;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        mdc_i = 1'b0;
  logic        mdio_i = 1'b1;
  logic        mdio_o, mdio_oe_o;
  logic [4:0]  reg_addr_o;
  logic        reg_rd_o, reg_wr_o;
  logic [15:0] reg_rdata_i = 16'h0000;
  logic [15:0] reg_wdata_o;

  mdio_slave dut (
    .clk_i(clk_i), .rst_i(rst_i), .mdc_i(mdc_i), .mdio_i(mdio_i),
    .mdio_o(mdio_o), .mdio_oe_o(mdio_oe_o), .reg_addr_o(reg_addr_o),
    .reg_rd_o(reg_rd_o), .reg_rdata_i(reg_rdata_i),
    .reg_wr_o(reg_wr_o), .reg_wdata_o(reg_wdata_o)
  );

  always #5 clk_i = ~clk_i;

`ifdef MDIO_SLAVE_PREAMBLE_SUPPRESS_EN
  localparam int SHORT_OK = 1;
`else
  localparam int SHORT_OK = 0;
`endif

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_rd = 0;
  int n_wr = 0;
  logic oe_seen = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk_i) begin
    exp_t e;
    if (mdio_oe_o) oe_seen = 1'b1;
    if (!rst_i && (reg_rd_o || reg_wr_o)) begin
      if (reg_rd_o) n_rd++;
      if (reg_wr_o) n_wr++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: got rd=%b wr=%b addr=%0d expected none",
                 reg_rd_o, reg_wr_o, reg_addr_o);
      end else begin
        e = sb.pop_front();
        check("strobe_kind", {31'd0, reg_wr_o}, {31'd0, e.wr});
        check("strobe_addr", {27'd0, reg_addr_o}, {27'd0, e.addr});
        if (e.wr) check("wdata", {16'd0, reg_wdata_o}, {16'd0, e.data});
      end
    end
  end

  task automatic mbit(input logic b, output logic s);
    mdio_i = b;
    #40;
    s = mdio_oe_o ? mdio_o : 1'b1;
    mdc_i = 1'b1;
    #40;
    mdc_i = 1'b0;
  endtask

  task automatic hdr(input int npre, input logic [1:0] op,
                     input logic [4:0] phy, input logic [4:0] ra);
    logic s;
    logic [13:0] f;
    f = {2'b01, op, phy, ra};
    repeat (npre) mbit(1'b1, s);
    for (int i = 13; i >= 0; i--) mbit(f[i], s);
  endtask

  task automatic tail_rd(input int n, output logic [17:0] rx);
    logic s;
    rx = '0;
    for (int i = 0; i < n; i++) begin
      mbit(1'b1, s);
      rx = {rx[16:0], s};
    end
  endtask

  task automatic tail_wr(input logic [1:0] ta, input logic [15:0] wd);
    logic s;
    logic [17:0] f;
    f = {ta, wd};
    for (int i = 17; i >= 0; i--) mbit(f[i], s);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic push(input logic wr, input logic [4:0] a, input logic [15:0] d);
    exp_t e;
    e.wr = wr;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  initial begin
    logic [17:0] rx;
    int wr0, rd0;
    repeat (3) @(negedge clk_i);
    check("rst_mdio_o", {31'd0, mdio_o}, 32'd1);
    check("rst_oe", {31'd0, mdio_oe_o}, 32'd0);
    check("rst_rd", {31'd0, reg_rd_o}, 32'd0);
    check("rst_wr", {31'd0, reg_wr_o}, 32'd0);
    check("rst_addr", {27'd0, reg_addr_o}, 32'd0);
    check("rst_wdata", {16'd0, reg_wdata_o}, 32'd0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // basic read
    reg_rdata_i = 16'hA5C3;
    push(1'b0, 5'd2, 16'h0);
    hdr(32, 2'b10, 5'd1, 5'd2);
    tail_rd(18, rx);
    @(negedge clk_i);
    check("rd_ta1_released", {31'd0, rx[17]}, 32'd1);
    check("rd_ta2_zero", {31'd0, rx[16]}, 32'd0);
    check("rd_data", {16'd0, rx[15:0]}, 32'h0000A5C3);
    check("rd_oe_after", {31'd0, mdio_oe_o}, 32'd0);
    check("rd_mdio_after", {31'd0, mdio_o}, 32'd1);
    check("rd_addr", {27'd0, reg_addr_o}, 32'd2);
    check("rd_count", n_rd, 1);

    // basic write
    oe_seen = 1'b0;
    push(1'b1, 5'd31, 16'h1234);
    hdr(32, 2'b01, 5'd1, 5'd31);
    tail_wr(2'b10, 16'h1234);
    repeat (4) @(negedge clk_i);
    check("wr_count", n_wr, 1);
    check("wr_wdata_held", {16'd0, reg_wdata_o}, 32'h1234);
    check("wr_addr", {27'd0, reg_addr_o}, 32'd31);
    check("wr_no_drive", {31'd0, oe_seen}, 32'd0);

    // wrong PHY address, then a good read
    oe_seen = 1'b0;
    hdr(32, 2'b10, 5'd3, 5'd9);
    tail_rd(18, rx);
    @(negedge clk_i);
    check("badphy_no_rd", n_rd, 1);
    check("badphy_no_drive", {31'd0, oe_seen}, 32'd0);
    check("badphy_addr_kept", {27'd0, reg_addr_o}, 32'd31);
    reg_rdata_i = 16'h0F0F;
    push(1'b0, 5'd5, 16'h0);
    hdr(32, 2'b10, 5'd1, 5'd5);
    tail_rd(18, rx);
    @(negedge clk_i);
    check("rd2_data", {16'd0, rx[15:0]}, 32'h00000F0F);
    check("rd2_count", n_rd, 2);

    // write with bad turnaround, and OP=11
    oe_seen = 1'b0;
    wr0 = n_wr;
    hdr(32, 2'b01, 5'd1, 5'd4);
    tail_wr(2'b11, 16'h0000);
    hdr(32, 2'b11, 5'd1, 5'd4);
    tail_wr(2'b10, 16'h5555);
    repeat (4) @(negedge clk_i);
    check("badta_op11_no_wr", n_wr, wr0);
    check("badta_wdata_kept", {16'd0, reg_wdata_o}, 32'h1234);
    check("badta_no_drive", {31'd0, oe_seen}, 32'd0);

    // short preamble right after reset
    do_reset();
    check("rst2_addr", {27'd0, reg_addr_o}, 32'd0);
    rd0 = n_rd;
    oe_seen = 1'b0;
    hdr(31, 2'b10, 5'd1, 5'd6);
    tail_rd(18, rx);
    @(negedge clk_i);
    check("pre31_no_rd", n_rd, rd0);
    check("pre31_no_drive", {31'd0, oe_seen}, 32'd0);

    // reset in the middle of read data
    reg_rdata_i = 16'hFFFF;
    push(1'b0, 5'd7, 16'h0);
    hdr(32, 2'b10, 5'd1, 5'd7);
    tail_rd(10, rx);
    check("mid_oe_driving", {31'd0, mdio_oe_o}, 32'd1);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("mid_rst_oe", {31'd0, mdio_oe_o}, 32'd0);
    check("mid_rst_mdio", {31'd0, mdio_o}, 32'd1);
    rst_i = 1'b0;
    tail_rd(8, rx);
    @(negedge clk_i);
    check("mid_rst_released", {31'd0, mdio_oe_o}, 32'd0);

    // completed read then write with a 1-bit preamble
    reg_rdata_i = 16'h8001;
    push(1'b0, 5'd8, 16'h0);
    hdr(32, 2'b10, 5'd1, 5'd8);
    tail_rd(18, rx);
    check("rd3_data", {16'd0, rx[15:0]}, 32'h00008001);
    wr0 = n_wr;
    if (SHORT_OK != 0) push(1'b1, 5'd12, 16'hBEEF);
    hdr(1, 2'b01, 5'd1, 5'd12);
    tail_wr(2'b10, 16'hBEEF);
    repeat (4) @(negedge clk_i);
    check("short_pre_wr", n_wr - wr0, SHORT_OK);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
